io_page_decoder: RTL and testbench



---
 rtl/io_page_decoder_pkg.sv | 37 +++
 rtl/io_page_decoder_if.sv | 33 +++
 rtl/io_page_decoder_wait_counter.sv | 30 +++
 rtl/io_page_decoder.sv | 196 +++++++++++++++++++
 tb/tb_io_page_decoder.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_page_decoder_pkg.sv
// ---------------------------------------------------------------------------
// io_dec_pkg
// Shared definitions for the FM-7 style main-CPU I/O page decoder:
//   - dec_state_t   : decoder FSM states
//   - IO_WINDOW_DEFAULT : default I/O window base (FD00)
//   - SLOT_*        : slot indices of the standard FD00-FD0F register map
// ---------------------------------------------------------------------------
package io_dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } dec_state_t;

    localparam logic [15:0] IO_WINDOW_DEFAULT = 16'hFD00;

    // Standard main-CPU I/O map, offset from the window base
    localparam int SLOT_KBD_CTL   = 0;   // FD00 keyboard / control
    localparam int SLOT_KBD_DATA  = 1;   // FD01 keyboard data
    localparam int SLOT_IRQ_MASK  = 2;   // FD02 IRQ mask / cassette
    localparam int SLOT_IRQ_STAT  = 3;   // FD03 IRQ status / beeper
    localparam int SLOT_SUB_CTL   = 4;   // FD04 sub-CPU control
    localparam int SLOT_SUB_HALT  = 5;   // FD05 sub-CPU halt / busy
    localparam int SLOT_RS_DATA   = 6;   // FD06 serial data
    localparam int SLOT_RS_CTL    = 7;   // FD07 serial control
    localparam int SLOT_PRN_DATA  = 8;   // FD08 printer data
    localparam int SLOT_PRN_STAT  = 9;   // FD09 printer status
    localparam int SLOT_FDC_A     = 10;  // FD0A
    localparam int SLOT_FDC_B     = 11;  // FD0B
    localparam int SLOT_PAL_A     = 12;  // FD0C palette
    localparam int SLOT_PAL_B     = 13;  // FD0D palette / PSG
    localparam int SLOT_PSG       = 14;  // FD0E PSG
    localparam int SLOT_BANK      = 15;  // FD0F ROM/RAM bank select

endpackage

// File: rtl/io_page_decoder_if.sv
// ---------------------------------------------------------------------------
// io_page_decoder_if
// CPU-side bus and decoded slot outputs of the I/O page decoder.
//   master : CPU side, drives addr/rw_n/vma/e/din, observes decoder outputs
//   slave  : decoder side
// Signals: addr[15:0], rw_n, vma, e, din[7:0]  (CPU -> decoder)
//          iosel_n, rd_en, wr_stb, wr_data, mrdy_n, busy (decoder -> CPU/IO)
// ---------------------------------------------------------------------------
interface io_page_decoder_if #(
    parameter int NUM_SLOTS = 16
);
    logic [15:0]          addr;
    logic                 rw_n;
    logic                 vma;
    logic                 e;
    logic [7:0]           din;
    logic                 iosel_n;
    logic [NUM_SLOTS-1:0] rd_en;
    logic [NUM_SLOTS-1:0] wr_stb;
    logic [7:0]           wr_data;
    logic                 mrdy_n;
    logic                 busy;

    modport master (
        output addr, rw_n, vma, e, din,
        input  iosel_n, rd_en, wr_stb, wr_data, mrdy_n, busy
    );

    modport slave (
        input  addr, rw_n, vma, e, din,
        output iosel_n, rd_en, wr_stb, wr_data, mrdy_n, busy
    );
endinterface

// File: rtl/io_page_decoder_wait_counter.sv
// ---------------------------------------------------------------------------
// io_wait_counter
// Loadable down-counter for wait-state stretching. done is high while the
// count equals 1, i.e. during the last stretched cycle.
// Ports: clk, reset_n (async, active-low), load/load_val, en, done
// ---------------------------------------------------------------------------
module io_wait_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             done
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign done = (count_reg == WIDTH'(1));
endmodule

// File: rtl/io_page_decoder.sv
// ---------------------------------------------------------------------------
// io_page_decoder
// Registered I/O window decoder for the 6809 main CPU. Decodes
// BASE_ADDR .. BASE_ADDR+2^SLOT_BITS-1 into one-hot read enables and
// single-cycle write strobes, one access per E cycle, with optional
// wait-state stretch (mrdy_n) for slots flagged in SLOW_MASK.
// Ports: clk, reset_n (async, active-low), bus (io_page_decoder_if.slave)
// Optional macro IO_DECODE_TRACE_EN adds last_addr, last_rw, access_cnt.
// ---------------------------------------------------------------------------
module io_page_decoder
    import io_dec_pkg::*;
#(
    parameter logic [15:0]          BASE_ADDR   = IO_WINDOW_DEFAULT,
    parameter int                   SLOT_BITS   = 4,
    parameter int                   NUM_SLOTS   = 16,
    parameter logic [NUM_SLOTS-1:0] SLOW_MASK   = '0,
    parameter int                   WAIT_CYCLES = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    io_page_decoder_if.slave   bus
`ifdef IO_DECODE_TRACE_EN
    ,
    output logic [15:0]        last_addr,
    output logic               last_rw,
    output logic [15:0]        access_cnt
`endif
);
    localparam logic [SLOT_BITS:0] SLOT_LIMIT = (SLOT_BITS + 1)'(NUM_SLOTS);

    dec_state_t             state_reg, state_next;
    logic [SLOT_BITS-1:0]   slot_reg, slot_next;
    logic                   rw_reg, rw_next;
    logic                   iosel_n_reg, iosel_n_next;
    logic [NUM_SLOTS-1:0]   rd_en_reg, rd_en_next;
    logic [NUM_SLOTS-1:0]   wr_stb_reg, wr_stb_next;
    logic [7:0]             wr_data_reg, wr_data_next;
    logic                   mrdy_n_reg, mrdy_n_next;
    logic                   e_q;
    logic                   rise, fall, hit, slow_hit;
    logic [SLOT_BITS-1:0]   offset;
    logic [NUM_SLOTS-1:0]   offset_oh, slot_oh;
    logic                   cnt_load, cnt_en, cnt_done;

    // E edge detection against the previous clk sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) e_q <= 1'b0;
        else          e_q <= bus.e;
    end

    assign rise   = bus.e & ~e_q;
    assign fall   = ~bus.e & e_q;
    assign offset = bus.addr[SLOT_BITS-1:0];
    assign hit    = bus.vma
                  & (bus.addr[15:SLOT_BITS] == BASE_ADDR[15:SLOT_BITS])
                  & ({1'b0, offset} < SLOT_LIMIT);

    // One-hot decodes of the live offset and the latched slot; the one-hot
    // form keeps SLOW_MASK lookups in range for unmapped offsets.
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign offset_oh[gi] = (offset == SLOT_BITS'(gi));
            assign slot_oh[gi]   = (slot_reg == SLOT_BITS'(gi));
        end
    endgenerate

    assign slow_hit = |(offset_oh & SLOW_MASK);

    io_wait_counter #(.WIDTH(8)) u_wait_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (8'(WAIT_CYCLES)),
        .en       (cnt_en),
        .done     (cnt_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            slot_reg    <= '0;
            rw_reg      <= 1'b1;
            iosel_n_reg <= 1'b1;
            rd_en_reg   <= '0;
            wr_stb_reg  <= '0;
            wr_data_reg <= 8'h00;
            mrdy_n_reg  <= 1'b1;
        end else begin
            state_reg   <= state_next;
            slot_reg    <= slot_next;
            rw_reg      <= rw_next;
            iosel_n_reg <= iosel_n_next;
            rd_en_reg   <= rd_en_next;
            wr_stb_reg  <= wr_stb_next;
            wr_data_reg <= wr_data_next;
            mrdy_n_reg  <= mrdy_n_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        slot_next    = slot_reg;
        rw_next      = rw_reg;
        iosel_n_next = iosel_n_reg;
        rd_en_next   = rd_en_reg;
        wr_stb_next  = '0;             // write strobe is always one cycle
        wr_data_next = wr_data_reg;
        mrdy_n_next  = mrdy_n_reg;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;

        case (state_reg)
            IDLE: begin
                // Also tidies up after a fall during STROBE
                rd_en_next   = '0;
                iosel_n_next = 1'b1;
                mrdy_n_next  = 1'b1;
                if (rise && hit) begin
                    slot_next    = offset;
                    rw_next      = bus.rw_n;
                    iosel_n_next = 1'b0;
                    if (slow_hit) begin
                        state_next  = WAIT;
                        cnt_load    = 1'b1;
                        mrdy_n_next = 1'b0;
                    end else begin
                        state_next  = STROBE;
                    end
                end
            end
            WAIT: begin
                cnt_en = 1'b1;
                if (fall) begin
                    // CPU ignored the stretch: drop the access silently
                    state_next   = IDLE;
                    mrdy_n_next  = 1'b1;
                    iosel_n_next = 1'b1;
                end else if (cnt_done) begin
                    state_next  = STROBE;
                    mrdy_n_next = 1'b1;
                end
            end
            STROBE: begin
                if (rw_reg) begin
                    rd_en_next = slot_oh;
                end else begin
                    wr_stb_next  = slot_oh;
                    wr_data_next = bus.din;
                end
                state_next = fall ? IDLE : HOLD;
            end
            HOLD: begin
                if (fall) begin
                    rd_en_next   = '0;
                    iosel_n_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.iosel_n = iosel_n_reg;
    assign bus.rd_en   = rd_en_reg;
    assign bus.wr_stb  = wr_stb_reg;
    assign bus.wr_data = wr_data_reg;
    assign bus.mrdy_n  = mrdy_n_reg;
    assign bus.busy    = (state_reg != IDLE);

`ifdef IO_DECODE_TRACE_EN
    logic        strobe_fire;
    logic [15:0] last_addr_reg;
    logic        last_rw_reg;
    logic [15:0] access_cnt_reg;

    assign strobe_fire = (state_reg == STROBE);

    // A hit implies the upper address bits equal the window base
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_addr_reg  <= 16'h0000;
            last_rw_reg    <= 1'b0;
            access_cnt_reg <= 16'h0000;
        end else if (strobe_fire) begin
            last_addr_reg  <= {BASE_ADDR[15:SLOT_BITS], slot_reg};
            last_rw_reg    <= rw_reg;
            access_cnt_reg <= access_cnt_reg + 16'd1;
        end
    end

    assign last_addr  = last_addr_reg;
    assign last_rw    = last_rw_reg;
    assign access_cnt = access_cnt_reg;
`endif

endmodule

// File: tb/tb_io_page_decoder.sv
// ---------------------------------------------------------------------------
// tb_io_page_decoder
// Directed self-checking bench for io_page_decoder configured with
// NUM_SLOTS=12, slot 2 slow, WAIT_CYCLES=3. Trace checks are compiled only
// when IO_DECODE_TRACE_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_io_page_decoder;
    localparam int NS = 12;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    io_page_decoder_if #(.NUM_SLOTS(NS)) bus ();

`ifdef IO_DECODE_TRACE_EN
    logic [15:0] last_addr;
    logic        last_rw;
    logic [15:0] access_cnt;
`endif

    io_page_decoder #(
        .BASE_ADDR   (16'hFD00),
        .SLOT_BITS   (4),
        .NUM_SLOTS   (NS),
        .SLOW_MASK   (12'h004),
        .WAIT_CYCLES (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus)
`ifdef IO_DECODE_TRACE_EN
        ,
        .last_addr  (last_addr),
        .last_rw    (last_rw),
        .access_cnt (access_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the active edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start an E cycle: drive bus and raise E just after an edge
    task automatic start_cycle(input logic [15:0] a, input logic rw, input logic [7:0] d);
        bus.addr = a;
        bus.rw_n = rw;
        bus.din  = d;
        bus.vma  = 1'b1;
        bus.e    = 1'b1;
    endtask

    task automatic end_cycle();
        bus.e   = 1'b0;
        bus.vma = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b1;
        bus.addr = 16'h0000;
        bus.rw_n = 1'b1;
        bus.vma  = 1'b0;
        bus.e    = 1'b0;
        bus.din  = 8'h00;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.iosel_n, bus.rd_en, bus.wr_stb, bus.wr_data, bus.mrdy_n, bus.busy}
            !== {1'b1, 12'h000, 12'h000, 8'h00, 1'b1, 1'b0})
            $display("FAIL reset_outputs: iosel_n=%b rd_en=%h wr_stb=%h wr_data=%h mrdy_n=%b busy=%b expected 1/000/000/00/1/0",
                     bus.iosel_n, bus.rd_en, bus.wr_stb, bus.wr_data, bus.mrdy_n, bus.busy);
        else n_pass++;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        $display("test_reset: done");
    endtask

    task automatic test_fast_write();
        start_cycle(16'hFD03, 1'b0, 8'h5A);
        tick();  // rise sampled
        n_checks++;
        if ({bus.wr_stb, bus.iosel_n, bus.busy, bus.mrdy_n} !== {12'h000, 1'b0, 1'b1, 1'b1})
            $display("FAIL fw_latch: wr_stb=%h iosel_n=%b busy=%b mrdy_n=%b expected 000/0/1/1",
                     bus.wr_stb, bus.iosel_n, bus.busy, bus.mrdy_n);
        else n_pass++;
        tick();  // 2 clk after rise: strobe
        n_checks++;
        if ({bus.wr_stb, bus.wr_data, bus.mrdy_n, bus.rd_en} !== {12'h008, 8'h5A, 1'b1, 12'h000})
            $display("FAIL fw_strobe: wr_stb=%h wr_data=%h mrdy_n=%b rd_en=%h expected 008/5a/1/000",
                     bus.wr_stb, bus.wr_data, bus.mrdy_n, bus.rd_en);
        else n_pass++;
        bus.din = 8'hFF;
        tick();
        n_checks++;
        if ({bus.wr_stb, bus.wr_data, bus.iosel_n} !== {12'h000, 8'h5A, 1'b0})
            $display("FAIL fw_strobe_end: wr_stb=%h wr_data=%h iosel_n=%b expected 000/5a/0",
                     bus.wr_stb, bus.wr_data, bus.iosel_n);
        else n_pass++;
        end_cycle();
        tick();  // fall sampled in HOLD
        n_checks++;
        if ({bus.iosel_n, bus.busy} !== {1'b1, 1'b0})
            $display("FAIL fw_release: iosel_n=%b busy=%b expected 1/0", bus.iosel_n, bus.busy);
        else n_pass++;
        tick();
        $display("test_fast_write: FD03 <= 5a done");
    endtask

    task automatic test_slow_read();
        start_cycle(16'hFD02, 1'b1, 8'h00);
        for (int i = 1; i <= 3; i++) begin
            tick();
            if (i == 2) begin
                // Changes after the latch must not affect the access
                bus.addr = 16'hFD03;
                bus.rw_n = 1'b0;
            end
            n_checks++;
            if ({bus.mrdy_n, bus.rd_en, bus.busy} !== {1'b0, 12'h000, 1'b1})
                $display("FAIL sr_stretch_%0d: mrdy_n=%b rd_en=%h busy=%b expected 0/000/1",
                         i, bus.mrdy_n, bus.rd_en, bus.busy);
            else n_pass++;
        end
        tick();  // clk 4: stretch released
        n_checks++;
        if ({bus.mrdy_n, bus.rd_en} !== {1'b1, 12'h000})
            $display("FAIL sr_release: mrdy_n=%b rd_en=%h expected 1/000", bus.mrdy_n, bus.rd_en);
        else n_pass++;
        for (int i = 5; i <= 7; i++) begin
            tick();
            n_checks++;
            if ({bus.rd_en, bus.wr_stb, bus.iosel_n} !== {12'h004, 12'h000, 1'b0})
                $display("FAIL sr_rd_en_clk%0d: rd_en=%h wr_stb=%h iosel_n=%b expected 004/000/0",
                         i, bus.rd_en, bus.wr_stb, bus.iosel_n);
            else n_pass++;
        end
        end_cycle();
        tick();
        n_checks++;
        if ({bus.rd_en, bus.iosel_n, bus.busy} !== {12'h000, 1'b1, 1'b0})
            $display("FAIL sr_fall: rd_en=%h iosel_n=%b busy=%b expected 000/1/0",
                     bus.rd_en, bus.iosel_n, bus.busy);
        else n_pass++;
        tick();
        $display("test_slow_read: FD02 read done");
    endtask

    task automatic test_unmapped();
        logic [15:0] addrs [2];
        addrs[0] = 16'hFD10;
        addrs[1] = 16'hFD0C;
        for (int k = 0; k < 2; k++) begin
            start_cycle(addrs[k], k[0], 8'h33);
            for (int i = 0; i < 4; i++) begin
                tick();
                n_checks++;
                if ({bus.rd_en, bus.wr_stb, bus.iosel_n, bus.busy, bus.mrdy_n}
                    !== {12'h000, 12'h000, 1'b1, 1'b0, 1'b1})
                    $display("FAIL unmapped_%h_clk%0d: rd_en=%h wr_stb=%h iosel_n=%b busy=%b mrdy_n=%b expected 000/000/1/0/1",
                             addrs[k], i, bus.rd_en, bus.wr_stb, bus.iosel_n, bus.busy, bus.mrdy_n);
                else n_pass++;
            end
            end_cycle();
            tick();
            tick();
            $display("test_unmapped: %h ignored", addrs[k]);
        end
    endtask

    task automatic test_abort();
        start_cycle(16'hFD02, 1'b0, 8'h77);
        tick();  // WAIT entered
        tick();  // 2nd WAIT clock
        n_checks++;
        if (bus.mrdy_n !== 1'b0)
            $display("FAIL abort_stretch: mrdy_n=%b expected 0", bus.mrdy_n);
        else n_pass++;
        end_cycle();
        tick();  // fall seen in WAIT
        n_checks++;
        if ({bus.mrdy_n, bus.busy, bus.iosel_n} !== {1'b1, 1'b0, 1'b1})
            $display("FAIL abort_idle: mrdy_n=%b busy=%b iosel_n=%b expected 1/0/1",
                     bus.mrdy_n, bus.busy, bus.iosel_n);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if ({bus.wr_stb, bus.rd_en, bus.wr_data} !== {12'h000, 12'h000, 8'h5A})
                $display("FAIL abort_no_strobe_%0d: wr_stb=%h rd_en=%h wr_data=%h expected 000/000/5a",
                         i, bus.wr_stb, bus.rd_en, bus.wr_data);
            else n_pass++;
        end
        $display("test_abort: FD02 write aborted");
    endtask

    task automatic test_back_to_back();
        start_cycle(16'hFD01, 1'b0, 8'h11);
        tick();
        tick();
        n_checks++;
        if ({bus.wr_stb, bus.wr_data} !== {12'h002, 8'h11})
            $display("FAIL b2b_first: wr_stb=%h wr_data=%h expected 002/11", bus.wr_stb, bus.wr_data);
        else n_pass++;
        tick();
        end_cycle();
        tick();
        start_cycle(16'hFD04, 1'b0, 8'h22);
        tick();
        tick();
        n_checks++;
        if ({bus.wr_stb, bus.wr_data} !== {12'h010, 8'h22})
            $display("FAIL b2b_second: wr_stb=%h wr_data=%h expected 010/22", bus.wr_stb, bus.wr_data);
        else n_pass++;
        tick();
        end_cycle();
        tick();
        tick();
        $display("test_back_to_back: FD01 <= 11, FD04 <= 22 done");
    endtask

    task automatic test_reset_mid_op();
        start_cycle(16'hFD02, 1'b1, 8'h00);
        tick();
        tick();
        n_checks++;
        if (bus.mrdy_n !== 1'b0)
            $display("FAIL rmo_wait: mrdy_n=%b expected 0", bus.mrdy_n);
        else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.iosel_n, bus.rd_en, bus.wr_stb, bus.wr_data, bus.mrdy_n, bus.busy}
            !== {1'b1, 12'h000, 12'h000, 8'h00, 1'b1, 1'b0})
            $display("FAIL rmo_async: iosel_n=%b rd_en=%h wr_stb=%h wr_data=%h mrdy_n=%b busy=%b expected 1/000/000/00/1/0",
                     bus.iosel_n, bus.rd_en, bus.wr_stb, bus.wr_data, bus.mrdy_n, bus.busy);
        else n_pass++;
        end_cycle();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        start_cycle(16'hFD07, 1'b0, 8'hA5);
        tick();
        tick();
        n_checks++;
        if ({bus.wr_stb, bus.wr_data, bus.mrdy_n} !== {12'h080, 8'hA5, 1'b1})
            $display("FAIL rmo_after: wr_stb=%h wr_data=%h mrdy_n=%b expected 080/a5/1",
                     bus.wr_stb, bus.wr_data, bus.mrdy_n);
        else n_pass++;
        tick();
        end_cycle();
        tick();
        n_checks++;
        if (bus.busy !== 1'b0)
            $display("FAIL rmo_idle: busy=%b expected 0", bus.busy);
        else n_pass++;
        tick();
        $display("test_reset_mid_op: reset during WAIT, FD07 <= a5 done");
    endtask

`ifdef IO_DECODE_TRACE_EN
    task automatic run_access(input logic [15:0] a, input logic rw, input logic [7:0] d);
        start_cycle(a, rw, d);
        tick();
        tick();
        tick();
        end_cycle();
        tick();
        tick();
    endtask

    task automatic test_trace();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) run_access(16'hFD05, 1'b0, 8'(i));
        n_checks++;
        if ({access_cnt, last_addr, last_rw} !== {16'd3, 16'hFD05, 1'b0})
            $display("FAIL trace_three: access_cnt=%h last_addr=%h last_rw=%b expected 0003/fd05/0",
                     access_cnt, last_addr, last_rw);
        else n_pass++;
        force dut.access_cnt_reg = 16'hFFFF;
        tick();
        release dut.access_cnt_reg;
        tick();
        run_access(16'hFD01, 1'b1, 8'h00);
        n_checks++;
        if ({access_cnt, last_addr, last_rw} !== {16'h0000, 16'hFD01, 1'b1})
            $display("FAIL trace_wrap: access_cnt=%h last_addr=%h last_rw=%b expected 0000/fd01/1",
                     access_cnt, last_addr, last_rw);
        else n_pass++;
        $display("test_trace: counter and last-access checks done");
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_fast_write();
        test_slow_read();
        test_unmapped();
        test_abort();
        test_back_to_back();
        test_reset_mid_op();
`ifdef IO_DECODE_TRACE_EN
        test_trace();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 ns, expected completion");
        $fatal(1, "timeout");
    end

endmodule
